axil_arbiter_2to1: RTL and testbench
====================================

Name: axil_arbiter_2to1

Overview:
- Two-master to one-slave AXI4-Lite arbiter that shares a single axi_lite_memory instance between two requesters, e.g. a CPU and a DMA/test master.
- Read and write paths are arbitrated independently, round-robin, with one outstanding transaction per path.
- Grants are locked from address phase through response handshake.
- Sits directly in front of the memory slave; passes data and responses through unchanged.

Parameters:
AXIL_DATA_WIDTH, 32, data width of all data/strobe ports (must be 32 to match memory)
AXIL_ADDR_WIDTH, 4, address width of all address ports

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-low reset
mN_awvalid, mN_awaddr / mN_awready  in, in / out  1, ADDR / 1  write address channel of master N (N = 0, 1)
mN_wvalid, mN_wdata, mN_wstrb / mN_wready  in / out  1, DATA, DATA/8 / 1  write data channel of master N
mN_bvalid, mN_bresp / mN_bready  out / in  1, 2 / 1  write response channel of master N
mN_arvalid, mN_araddr / mN_arready  in / out  1, ADDR / 1  read address channel of master N
mN_rvalid, mN_rdata, mN_rresp / mN_rready  out / in  1, DATA, 2 / 1  read data channel of master N
s_awvalid, s_awaddr / s_awready  out / in  1, ADDR / 1  write address to slave
s_wvalid, s_wdata, s_wstrb / s_wready  out / in  1, DATA, DATA/8 / 1  write data to slave
s_bvalid, s_bresp / s_bready  in / out  1, 2 / 1  write response from slave
s_arvalid, s_araddr / s_arready  out / in  1, ADDR / 1  read address to slave
s_rvalid, s_rdata, s_rresp / s_rready  in / out  1, DATA, 2 / 1  read data from slave

Behaviour:
- Reset (async, reset=0): both FSMs go to IDLE; both rr pointers favour master 0. All valid/ready outputs toward masters and slave are 0 while in IDLE. Data, address and resp outputs are don't-care but driven from the mux, with no X when grant=0.
- Write FSM states: W_IDLE, W_ADDR, W_RESP.
  - W_IDLE: request is mN_awvalid. If exactly one master requests, grant it. If both request, grant the master != last_wgrant. Register the grant and go to W_ADDR. Arbitration costs 1 cycle; no forwarding occurs in W_IDLE.
  - W_ADDR: AW and W of the granted master are forwarded combinationally (valid/payload to slave, ready back to master). aw_done/w_done set on the respective handshake and are cleared on entry. Once an AW handshake has completed, s_awvalid is masked to 0; likewise for W. Go to W_RESP when both are done; same-cycle completion counts.
  - W_RESP: s_bvalid/s_bresp are forwarded to the granted master; s_bready = mN_bready. On s_bvalid & s_bready: go to W_IDLE and set last_wgrant = granted master.
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Same rules as the write FSM, using mN_arvalid, the AR handshake, and the R handshake (s_rvalid & s_rready). Uses its own last_rgrant pointer.
- Non-granted master sees ready=0 and valid=0 on every channel; its valid/payload must stay held (AXI rule). The arbiter does not drop requests.
- wvalid without awvalid never requests a grant. W arriving before or after AW within W_ADDR is accepted.
- Read and write paths are fully independent. The same or different masters may hold both grants simultaneously.
- No combinational path from mN_*valid to s_*valid in IDLE states; minimum transaction latency is 1 arbitration cycle plus the slave latency.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0. The in-flight slave transaction is abandoned (memory resets too).
- bresp/rresp are passed through unmodified.

Decomposition:
- Shared package axil_arb_pkg holds: FSM state localparams (ST_IDLE, ST_ADDR, ST_RESP, 2-bit), master index constants (M0=0, M1=1), and OKAY response code 2'b00.
- Natural sub-module: axil_rr_arb2, a 2-requester round-robin arbiter with lock/release inputs and a last-grant register. It is instantiated once for the write path and once for the read path. Channel muxing stays in the top level.

Test Plan:
- m0 writes 0xDEADBEEF, wstrb=0xF, to addr 3; m0 then reads addr 3 -> m0_bvalid with bresp=0, then m0_rdata=0xDEADBEEF. All m1 ready/valid signals stay 0 throughout.
- m0 and m1 assert awvalid in the same cycle after reset (m0 addr 1 data 0x11111111, m1 addr 2 data 0x22222222) -> m0 is granted first, m1 second. A second simultaneous pair is granted m1 first (round-robin).
- m1 presents wvalid 2 cycles before awvalid, wstrb=0x3, data 0xAAAA5555 to addr 5 preloaded 0x12345678 -> single write, mem[5]=0x12345555, exactly one s_awvalid and one s_wvalid handshake.
- m0 holds mN_bready=0 for 4 cycles -> s_bready=0, write FSM stays in W_RESP, m1 awvalid not granted until the B handshake. Meanwhile m1 read of addr 1 completes concurrently.
- Both masters issue 8 back-to-back reads -> reads alternate m0/m1 strictly, and each rdata matches that master's address.
- Assert reset during W_ADDR -> all s_*valid and mN_*ready drop to 0 in the same cycle without a clock edge. After release, a new m1 write completes normally.

Source files
------------

// File: rtl/axil_arb_pkg.sv
// Shared definitions for the 2:1 AXI4-Lite arbiter.
//   arb_state_e : per-path FSM state (idle / address phase / response phase)
//   M0, M1      : master index constants used as grant values
//   RESP_OKAY   : AXI OKAY response code
//   rr_pick     : round-robin winner for a 2-bit request vector
package axil_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam logic       M0        = 1'b0;
  localparam logic       M1        = 1'b1;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // A lone requester always wins; on a tie the master that did not win last time goes.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    case (req)
      2'b01:   pick = M0;
      2'b10:   pick = M1;
      2'b11:   pick = ~last_grant;
      default: pick = M0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/axil_arbiter_2to1_if.sv
// AXI4-Lite bundle (AW, W, B, AR, R channels).
//   master modport : the side that issues requests (drives valids/payload, bready/rready)
//   slave modport  : the side that answers (drives readies, bvalid/bresp, rvalid/rdata/rresp)
interface axil_arbiter_2to1_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_rr_arb2.sv
// Two-requester round-robin arbiter with a locked grant.
//   clk, reset : clock, asynchronous active-low reset
//   req        : request vector, bit N = master N
//   lock_en    : capture the round-robin winner into grant
//   release_en : transaction finished; the current grant becomes the last grant
//   grant      : registered, locked grant (M0 after reset)
module axil_rr_arb2
  import axil_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       lock_en,
  input  logic       release_en,
  output logic       grant
);

  logic last_grant_r;

  // Grant capture and round-robin history; last grant starts at M1 so a tie after reset goes to M0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant        <= M0;
      last_grant_r <= M1;
    end else begin
      if (lock_en) begin
        grant <= rr_pick(req, last_grant_r);
      end
      if (release_en) begin
        last_grant_r <= grant;
      end
    end
  end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter. Write and read paths are arbitrated
// independently (round-robin, one outstanding transaction each); a grant is held
// from the address phase until the response handshake.
//   clk, reset : clock, asynchronous active-low reset
//   m0, m1     : upstream masters (slave modport of the bundle)
//   s          : downstream memory slave (master modport of the bundle)
module axil_arbiter_2to1
  import axil_arb_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  axil_arbiter_2to1_if.slave   m0,
  axil_arbiter_2to1_if.slave   m1,
  axil_arbiter_2to1_if.master  s
);

  // ---------------- write path ----------------
  arb_state_e wstate_r;
  logic       aw_done_r;
  logic       w_done_r;
  logic       wgrant_s;
  logic       wlock_s;
  logic       wrel_s;
  logic       aw_hs_s;
  logic       w_hs_s;
  logic       w_addr_ph_s;
  logic       w_resp_ph_s;

  logic [AXIL_ADDR_WIDTH-1:0]   awaddr_mux_s;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_mux_s;
  logic [AXIL_DATA_WIDTH/8-1:0] wstrb_mux_s;

  assign w_addr_ph_s = (wstate_r == ST_ADDR);
  assign w_resp_ph_s = (wstate_r == ST_RESP);
  // Only awvalid requests a write grant; a lone wvalid waits for its address.
  assign wlock_s     = (wstate_r == ST_IDLE) && (m0.awvalid || m1.awvalid);
  assign wrel_s      = w_resp_ph_s && s.bvalid && s.bready;
  assign aw_hs_s     = s.awvalid && s.awready;
  assign w_hs_s      = s.wvalid && s.wready;

  axil_rr_arb2 u_warb (
    .clk        (clk),
    .reset      (reset),
    .req        ({m1.awvalid, m0.awvalid}),
    .lock_en    (wlock_s),
    .release_en (wrel_s),
    .grant      (wgrant_s)
  );

  // Write FSM: arbitration cycle, AW/W forwarding until both complete, then B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate_r  <= ST_IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      case (wstate_r)
        ST_IDLE: begin
          if (wlock_s) begin
            wstate_r  <= ST_ADDR;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (aw_hs_s) aw_done_r <= 1'b1;
          if (w_hs_s)  w_done_r  <= 1'b1;
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            wstate_r <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (wrel_s) wstate_r <= ST_IDLE;
        end
        default: wstate_r <= ST_IDLE;
      endcase
    end
  end

  // Payload always follows the grant so the slave never sees X, even when idle.
  assign awaddr_mux_s = wgrant_s ? m1.awaddr : m0.awaddr;
  assign wdata_mux_s  = wgrant_s ? m1.wdata  : m0.wdata;
  assign wstrb_mux_s  = wgrant_s ? m1.wstrb  : m0.wstrb;

  assign s.awaddr  = awaddr_mux_s;
  assign s.wdata   = wdata_mux_s;
  assign s.wstrb   = wstrb_mux_s;
  // A completed channel is masked so the slave sees exactly one handshake per channel.
  assign s.awvalid = w_addr_ph_s && !aw_done_r && (wgrant_s ? m1.awvalid : m0.awvalid);
  assign s.wvalid  = w_addr_ph_s && !w_done_r  && (wgrant_s ? m1.wvalid  : m0.wvalid);
  assign s.bready  = w_resp_ph_s && (wgrant_s ? m1.bready : m0.bready);

  assign m0.awready = w_addr_ph_s && !aw_done_r && (wgrant_s == M0) && s.awready;
  assign m1.awready = w_addr_ph_s && !aw_done_r && (wgrant_s == M1) && s.awready;
  assign m0.wready  = w_addr_ph_s && !w_done_r  && (wgrant_s == M0) && s.wready;
  assign m1.wready  = w_addr_ph_s && !w_done_r  && (wgrant_s == M1) && s.wready;
  assign m0.bvalid  = w_resp_ph_s && (wgrant_s == M0) && s.bvalid;
  assign m1.bvalid  = w_resp_ph_s && (wgrant_s == M1) && s.bvalid;
  assign m0.bresp   = s.bresp;
  assign m1.bresp   = s.bresp;

  // ---------------- read path ----------------
  arb_state_e rstate_r;
  logic       rgrant_s;
  logic       rlock_s;
  logic       rrel_s;
  logic       ar_hs_s;
  logic       r_addr_ph_s;
  logic       r_data_ph_s;

  logic [AXIL_ADDR_WIDTH-1:0] araddr_mux_s;

  assign r_addr_ph_s = (rstate_r == ST_ADDR);
  assign r_data_ph_s = (rstate_r == ST_RESP);
  assign rlock_s     = (rstate_r == ST_IDLE) && (m0.arvalid || m1.arvalid);
  assign rrel_s      = r_data_ph_s && s.rvalid && s.rready;
  assign ar_hs_s     = s.arvalid && s.arready;

  axil_rr_arb2 u_rarb (
    .clk        (clk),
    .reset      (reset),
    .req        ({m1.arvalid, m0.arvalid}),
    .lock_en    (rlock_s),
    .release_en (rrel_s),
    .grant      (rgrant_s)
  );

  // Read FSM: arbitration cycle, AR forwarding, then R until its handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rstate_r <= ST_IDLE;
    end else begin
      case (rstate_r)
        ST_IDLE: begin
          if (rlock_s) rstate_r <= ST_ADDR;
        end
        ST_ADDR: begin
          if (ar_hs_s) rstate_r <= ST_RESP;
        end
        ST_RESP: begin
          if (rrel_s) rstate_r <= ST_IDLE;
        end
        default: rstate_r <= ST_IDLE;
      endcase
    end
  end

  assign araddr_mux_s = rgrant_s ? m1.araddr : m0.araddr;
  assign s.araddr     = araddr_mux_s;
  assign s.arvalid    = r_addr_ph_s && (rgrant_s ? m1.arvalid : m0.arvalid);
  assign s.rready     = r_data_ph_s && (rgrant_s ? m1.rready : m0.rready);

  assign m0.arready = r_addr_ph_s && (rgrant_s == M0) && s.arready;
  assign m1.arready = r_addr_ph_s && (rgrant_s == M1) && s.arready;
  assign m0.rvalid  = r_data_ph_s && (rgrant_s == M0) && s.rvalid;
  assign m1.rvalid  = r_data_ph_s && (rgrant_s == M1) && s.rvalid;
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;
  assign m0.rresp   = s.rresp;
  assign m1.rresp   = s.rresp;

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Self-checking bench for axil_arbiter_2to1 with a small AXI4-Lite memory model
// as the slave. Inputs change on the falling edge; outputs are sampled shortly after it.
module tb_axil_arbiter_2to1;
  import axil_arb_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axil_arbiter_2to1_if m0_if ();
  axil_arbiter_2to1_if m1_if ();
  axil_arbiter_2to1_if s_if ();

  axil_arbiter_2to1 #(.AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  // ---------------- master drive arrays ----------------
  logic [1:0]  awvalid_d = 2'b00, wvalid_d = 2'b00, bready_d = 2'b00;
  logic [1:0]  arvalid_d = 2'b00, rready_d = 2'b00;
  logic [3:0]  awaddr_d [2] = '{4'h0, 4'h0};
  logic [3:0]  araddr_d [2] = '{4'h0, 4'h0};
  logic [31:0] wdata_d  [2] = '{32'h0, 32'h0};
  logic [3:0]  wstrb_d  [2] = '{4'h0, 4'h0};

  assign m0_if.awvalid = awvalid_d[0];  assign m1_if.awvalid = awvalid_d[1];
  assign m0_if.awaddr  = awaddr_d[0];   assign m1_if.awaddr  = awaddr_d[1];
  assign m0_if.wvalid  = wvalid_d[0];   assign m1_if.wvalid  = wvalid_d[1];
  assign m0_if.wdata   = wdata_d[0];    assign m1_if.wdata   = wdata_d[1];
  assign m0_if.wstrb   = wstrb_d[0];    assign m1_if.wstrb   = wstrb_d[1];
  assign m0_if.bready  = bready_d[0];   assign m1_if.bready  = bready_d[1];
  assign m0_if.arvalid = arvalid_d[0];  assign m1_if.arvalid = arvalid_d[1];
  assign m0_if.araddr  = araddr_d[0];   assign m1_if.araddr  = araddr_d[1];
  assign m0_if.rready  = rready_d[0];   assign m1_if.rready  = rready_d[1];

  logic [1:0]  awready_o, wready_o, bvalid_o, arready_o, rvalid_o;
  logic [1:0]  bresp_o [2];
  logic [1:0]  rresp_o [2];
  logic [31:0] rdata_o [2];
  assign awready_o = {m1_if.awready, m0_if.awready};
  assign wready_o  = {m1_if.wready,  m0_if.wready};
  assign bvalid_o  = {m1_if.bvalid,  m0_if.bvalid};
  assign arready_o = {m1_if.arready, m0_if.arready};
  assign rvalid_o  = {m1_if.rvalid,  m0_if.rvalid};
  assign bresp_o[0] = m0_if.bresp;  assign bresp_o[1] = m1_if.bresp;
  assign rresp_o[0] = m0_if.rresp;  assign rresp_o[1] = m1_if.rresp;
  assign rdata_o[0] = m0_if.rdata;  assign rdata_o[1] = m1_if.rdata;

  // ---------------- memory slave model ----------------
  logic [31:0] mem [16];
  logic        aw_got, w_got, sb_valid, sr_valid;
  logic [3:0]  sa_addr, sw_strb;
  logic [31:0] sw_data, sr_data;

  assign s_if.awready = !aw_got && !sb_valid;
  assign s_if.wready  = !w_got && !sb_valid;
  assign s_if.bvalid  = sb_valid;
  assign s_if.bresp   = RESP_OKAY;
  assign s_if.arready = !sr_valid;
  assign s_if.rvalid  = sr_valid;
  assign s_if.rdata   = sr_data;
  assign s_if.rresp   = RESP_OKAY;

  // Memory slave: latches AW and W independently, writes once both are held, then answers B.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
      aw_got <= 1'b0; w_got <= 1'b0; sb_valid <= 1'b0; sr_valid <= 1'b0;
      sa_addr <= 4'h0; sw_strb <= 4'h0; sw_data <= 32'h0; sr_data <= 32'h0;
    end else begin
      if (s_if.awvalid && s_if.awready) begin aw_got <= 1'b1; sa_addr <= s_if.awaddr; end
      if (s_if.wvalid && s_if.wready) begin
        w_got <= 1'b1; sw_data <= s_if.wdata; sw_strb <= s_if.wstrb;
      end
      if (aw_got && w_got && !sb_valid) begin
        for (int b = 0; b < 4; b++)
          if (sw_strb[b]) mem[sa_addr][8*b +: 8] <= sw_data[8*b +: 8];
        sb_valid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (sb_valid && s_if.bready) begin
        sb_valid <= 1'b0;
      end
      if (s_if.arvalid && s_if.arready) begin
        sr_valid <= 1'b1; sr_data <= mem[s_if.araddr];
      end else if (sr_valid && s_if.rready) begin
        sr_valid <= 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, s_aw_cnt = 0, s_w_cnt = 0, m1_act = 0;
  int m0_b_cyc = 0, m1_aw_cyc = 0, m1_r_cyc = 0;
  int wr_order[$];
  int rd_order[$];

  // Handshake monitor, sampled mid-cycle where every signal is stable until the next rising edge.
  always begin
    @(negedge clk);
    #2;
    cyc <= cyc + 1;
    if (s_if.awvalid && s_if.awready) s_aw_cnt <= s_aw_cnt + 1;
    if (s_if.wvalid && s_if.wready)   s_w_cnt  <= s_w_cnt + 1;
    if (m1_if.awready || m1_if.wready || m1_if.bvalid || m1_if.arready || m1_if.rvalid)
      m1_act <= m1_act + 1;
    if (m0_if.bvalid && m0_if.bready) begin wr_order.push_back(0); m0_b_cyc <= cyc; end
    if (m1_if.bvalid && m1_if.bready) wr_order.push_back(1);
    if (m1_if.awvalid && m1_if.awready) m1_aw_cyc <= cyc;
    if (m0_if.rvalid && m0_if.rready) rd_order.push_back(0);
    if (m1_if.rvalid && m1_if.rready) begin rd_order.push_back(1); m1_r_cyc <= cyc; end
  end

  // ---------------- checking helpers ----------------
  int total = 0, bad = 0;
  logic [31:0] exp_mem [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] vr_flags();
    return {s_if.awvalid, s_if.wvalid, s_if.bready, s_if.arvalid, s_if.rready,
            m0_if.awready, m0_if.wready, m0_if.bvalid, m0_if.arready, m0_if.rvalid,
            m1_if.awready, m1_if.wready, m1_if.bvalid, m1_if.arready, m1_if.rvalid, 1'b0};
  endfunction

  task automatic clear_exp();
    for (int k = 0; k < 16; k++) exp_mem[k] = 32'h0;
  endtask

  // w_lead: cycles wvalid leads awvalid; b_hold: cycles bready stays low after AW/W complete.
  task automatic do_write(input int m, input logic [3:0] a, input logic [31:0] d,
                          input logic [3:0] st, input int w_lead, input int b_hold,
                          output logic [1:0] resp);
    bit aw_ok, w_ok, b_ok, ah, wh;
    int n;
    resp = 2'b11;
    @(negedge clk);
    wdata_d[m] = d; wstrb_d[m] = st;
    if (w_lead > 0) begin
      wvalid_d[m] = 1'b1;
      repeat (w_lead) begin
        #1 chk("w_early_wready", {31'h0, wready_o[m]}, 32'h0);
        @(negedge clk);
      end
    end
    awvalid_d[m] = 1'b1; awaddr_d[m] = a; wvalid_d[m] = 1'b1;
    bready_d[m] = (b_hold == 0);
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 50) begin
      #1;
      ah = awvalid_d[m] && awready_o[m];
      wh = wvalid_d[m] && wready_o[m];
      @(posedge clk); @(negedge clk);
      if (ah) begin awvalid_d[m] = 1'b0; aw_ok = 1'b1; end
      if (wh) begin wvalid_d[m] = 1'b0; w_ok = 1'b1; end
      n++;
    end
    awvalid_d[m] = 1'b0; wvalid_d[m] = 1'b0;
    chk("wr_addr_phase", {30'h0, aw_ok, w_ok}, 32'h3);
    if (b_hold > 0) begin
      repeat (b_hold) begin
        #1 chk("bready_held", {31'h0, s_if.bready}, 32'h0);
        @(negedge clk);
      end
      #1 chk("bvalid_waiting", {31'h0, bvalid_o[m]}, 32'h1);
      bready_d[m] = 1'b1;
    end
    b_ok = 1'b0; n = 0;
    while (!b_ok && n < 50) begin
      #1;
      if (bvalid_o[m] && bready_d[m]) begin b_ok = 1'b1; resp = bresp_o[m]; end
      @(posedge clk); @(negedge clk);
      n++;
    end
    bready_d[m] = 1'b0;
    chk("wr_resp_phase", {31'h0, b_ok}, 32'h1);
    if (b_ok)
      for (int b = 0; b < 4; b++)
        if (st[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_read(input int m, input logic [3:0] a,
                         output logic [31:0] d, output logic [1:0] rs);
    bit ar_ok, r_ok, ah, rh;
    int n;
    d = 32'h0; rs = 2'b11;
    @(negedge clk);
    arvalid_d[m] = 1'b1; araddr_d[m] = a; rready_d[m] = 1'b1;
    ar_ok = 1'b0; r_ok = 1'b0; n = 0;
    while (!r_ok && n < 60) begin
      #1;
      ah = arvalid_d[m] && arready_o[m];
      rh = rvalid_o[m] && rready_d[m];
      if (rh) begin d = rdata_o[m]; rs = rresp_o[m]; end
      @(posedge clk); @(negedge clk);
      if (ah) begin arvalid_d[m] = 1'b0; ar_ok = 1'b1; end
      if (rh) r_ok = 1'b1;
      n++;
    end
    arvalid_d[m] = 1'b0; rready_d[m] = 1'b0;
    chk("rd_done", {31'h0, r_ok}, 32'h1);
  endtask

  typedef struct {
    int          m;
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [1:0]  r2, r3;
    logic [31:0] rd;
    int act0, ws, rs0, s_aw0, s_w0, alt_err;
    logic [4:0] ord;

    tbl[0] = '{0, 1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{0, 1'b0, 4'd3,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1, 1'b1, 4'd5,  32'h12345678, 4'hF, 32'h0};
    tbl[3] = '{1, 1'b0, 4'd5,  32'h0,        4'h0, 32'h12345678};
    tbl[4] = '{0, 1'b1, 4'd6,  32'hAABBCCDD, 4'h5, 32'h0};
    tbl[5] = '{1, 1'b0, 4'd6,  32'h0,        4'h0, 32'h00BB00DD};
    tbl[6] = '{1, 1'b1, 4'd15, 32'hFFFFFFFF, 4'h8, 32'h0};
    tbl[7] = '{0, 1'b0, 4'd15, 32'h0,        4'h0, 32'hFF000000};

    clear_exp();
    #2 reset = 1'b0;
    #1;
    chk("reset_flags", {16'h0, vr_flags()}, 32'h0);
    chk("reset_awaddr", {28'h0, s_if.awaddr}, 32'h0);
    chk("reset_araddr", {28'h0, s_if.araddr}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Table of single transactions; master 1 must stay silent during the first two.
    act0 = m1_act;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, r2);
        chk($sformatf("vec%0d_bresp", i), {30'h0, r2}, {30'h0, RESP_OKAY});
      end else begin
        do_read(tbl[i].m, tbl[i].addr, rd, r2);
        chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
        chk($sformatf("vec%0d_rresp", i), {30'h0, r2}, {30'h0, RESP_OKAY});
      end
      if (i == 1) chk("m1_silent", m1_act - act0, 32'h0);
    end

    // Fresh reset: simultaneous pair goes m0 first; after a lone m0 write the next pair goes m1 first.
    @(negedge clk); reset = 1'b0; clear_exp();
    @(negedge clk); reset = 1'b1;
    ws = wr_order.size();
    fork
      do_write(0, 4'd1, 32'h11111111, 4'hF, 0, 0, r2);
      do_write(1, 4'd2, 32'h22222222, 4'hF, 0, 0, r3);
    join
    do_write(0, 4'd4, 32'h44444444, 4'hF, 0, 0, r2);
    fork
      do_write(0, 4'd10, 32'hA0A0A0A0, 4'hF, 0, 0, r2);
      do_write(1, 4'd11, 32'hB1B1B1B1, 4'hF, 0, 0, r3);
    join
    chk("pair_count", wr_order.size() - ws, 32'd5);
    ord = 5'b0;
    for (int k = 0; k < 5; k++) ord = {ord[3:0], wr_order[ws + k] == 1};
    chk("pair_order", {27'h0, ord}, 32'b01010);

    // W ahead of AW: one write, one handshake per channel, byte-merged result.
    do_write(0, 4'd5, 32'h12345678, 4'hF, 0, 0, r2);
    s_aw0 = s_aw_cnt; s_w0 = s_w_cnt;
    do_write(1, 4'd5, 32'hAAAA5555, 4'h3, 2, 0, r2);
    chk("early_w_bresp", {30'h0, r2}, 32'h0);
    chk("early_w_aw_hs", s_aw_cnt - s_aw0, 32'd1);
    chk("early_w_w_hs", s_w_cnt - s_w0, 32'd1);
    do_read(1, 4'd5, rd, r2);
    chk("early_w_merge", rd, 32'h12345555);

    // m0 stalls B; m1 write waits for it while an m1 read finishes meanwhile.
    fork
      do_write(0, 4'd8, 32'h88888888, 4'hF, 0, 4, r2);
      begin @(negedge clk); do_write(1, 4'd9, 32'h99999999, 4'hF, 0, 0, r3); end
      begin @(negedge clk); do_read(1, 4'd1, rd, r2); end
    join
    chk("stall_m1_read", rd, 32'h11111111);
    chk("stall_m1_aw_after_b", {31'h0, m1_aw_cyc > m0_b_cyc}, 32'h1);
    chk("stall_read_before_b", {31'h0, m1_r_cyc < m0_b_cyc}, 32'h1);

    // Back-to-back reads from both masters must alternate.
    rs0 = rd_order.size();
    fork
      begin
        logic [31:0] d0; logic [1:0] q0;
        for (int i = 0; i < 8; i++) begin
          do_read(0, i[3:0], d0, q0);
          chk($sformatf("b2b_m0_%0d", i), d0, exp_mem[i]);
        end
      end
      begin
        logic [31:0] d1; logic [1:0] q1;
        for (int j = 0; j < 8; j++) begin
          do_read(1, 4'(j + 8), d1, q1);
          chk($sformatf("b2b_m1_%0d", j), d1, exp_mem[j + 8]);
        end
      end
    join
    chk("b2b_count", rd_order.size() - rs0, 32'd16);
    alt_err = 0;
    for (int k = rs0 + 1; k < rd_order.size(); k++)
      if (rd_order[k] == rd_order[k - 1]) alt_err++;
    chk("b2b_alternate", alt_err, 32'd0);

    // Reset while the write path waits for W: everything drops without a clock edge.
    @(negedge clk);
    awvalid_d[0] = 1'b1; awaddr_d[0] = 4'd3;
    repeat (2) @(negedge clk);
    #1 chk("waddr_wready", {31'h0, m0_if.wready}, 32'h1);
    #2 reset = 1'b0;
    #1 chk("midrst_flags", {16'h0, vr_flags()}, 32'h0);
    @(negedge clk); awvalid_d[0] = 1'b0; clear_exp();
    @(negedge clk); reset = 1'b1;
    do_write(1, 4'd7, 32'h77777777, 4'hF, 0, 0, r2);
    chk("post_rst_bresp", {30'h0, r2}, 32'h0);
    do_read(1, 4'd7, rd, r2);
    chk("post_rst_rdata", rd, 32'h77777777);
    do_read(0, 4'd3, rd, r2);
    chk("post_rst_cleared", rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
